bus_req_arbiter: RTL

Round-robin arbiter that shares one downstream bus port among 2^N_SEL requesters in the RV32 core, e.g. the fetch, load/store and debug paths sharing one memory port. It selects one requester, drives the shared mux select and packed data path, holds the grant for one handshake, and returns completion or timeout status to the winner. It sequences the packed-input mux used elsewhere in the design, and its `bus_sel` output is directly compatible with that mux's select input.

---
 rtl/bus_req_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter sharing one bus port among 2**N_SEL requesters.
// Holds the grant for one handshake and reports done or timeout to the winner.
module bus_req_arbiter #(
    parameter int N_SEL   = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [(1<<N_SEL)-1:0]           req,
    input  logic [(1<<N_SEL)*WIDTH-1:0]     req_data,
    output logic [(1<<N_SEL)-1:0]           gnt,
    output logic [(1<<N_SEL)-1:0]           done,
    output logic [(1<<N_SEL)-1:0]           err,
    output logic                            bus_valid,
    output logic [N_SEL-1:0]                bus_sel,
    output logic [WIDTH-1:0]                bus_data,
    input  logic                            bus_ready
);

    localparam int NREQ = 1 << N_SEL;
    localparam int WCW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WLIMIT = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [N_SEL-1:0] ptr_q, ptr_d;
    logic [N_SEL-1:0] sel_q, sel_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [N_SEL-1:0] winner;
    logic             found;

    // Rotating priority scan starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[ptr_q + N_SEL'(k)]) begin
                found  = 1'b1;
                winner = ptr_q + N_SEL'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        wcnt_d    = wcnt_q;
        gnt       = '0;
        done      = '0;
        err       = '0;
        bus_valid = 1'b0;
        bus_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = winner;
                    wcnt_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus_valid  = 1'b1;
                gnt[sel_q] = 1'b1;
                bus_data   = req_data[sel_q*WIDTH +: WIDTH];
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + N_SEL'(1);
                end else if (bus_ready) begin
                    done[sel_q] = 1'b1;
                    state_d     = IDLE;
                    ptr_d       = sel_q + N_SEL'(1);
                end else if (TIMEOUT != 0 && wcnt_q == WLIMIT) begin
                    err[sel_q] = 1'b1;
                    state_d    = IDLE;
                    ptr_d      = sel_q + N_SEL'(1);
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus_sel = sel_q;

endmodule
